// File: rtl/cdb_pkg.sv
// Shared definitions for the CDB round-robin arbiter.
// Tag convention: unit i broadcasts tag i+1; tag 0 means "no producer".
package cdb_pkg;

    localparam int FREE_REGISTER = 0;
    localparam int N_UNITS_DEF   = 4;
    localparam int DATA_W_DEF    = 16;
    localparam int TAG_W_DEF     = 3;

    function automatic int unit_tag(input int idx);
        return idx + 1;
    endfunction

endpackage

// File: rtl/cdb_rr_arbiter_if.sv
// Result-bus bundle between functional units (master) and the CDB arbiter (slave).
interface cdb_rr_arbiter_if
    import cdb_pkg::*;
#(
    parameter int N_UNITS = N_UNITS_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TAG_W   = TAG_W_DEF
);

    logic                        Write_Enable_CDB;
    logic [N_UNITS-1:0]          Done;
    logic [N_UNITS*DATA_W-1:0]   Q_data;
    logic [N_UNITS-1:0]          Grant;
    logic                        CDB_Valid;
    logic [TAG_W-1:0]            Qi_CDB;
    logic [DATA_W-1:0]           Qi_CDB_data;

    modport master (
        output Write_Enable_CDB,
        output Done,
        output Q_data,
        input  Grant,
        input  CDB_Valid,
        input  Qi_CDB,
        input  Qi_CDB_data
    );

    modport slave (
        input  Write_Enable_CDB,
        input  Done,
        input  Q_data,
        output Grant,
        output CDB_Valid,
        output Qi_CDB,
        output Qi_CDB_data
    );

endinterface

// File: rtl/rr_priority_picker.sv
// Wrap-around priority search: first requester at or after start wins.
module rr_priority_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int best_d;
    int d;

    // Winner is the requester with the smallest forward distance from start.
    always_comb begin
        best_d = N;
        d      = 0;
        idx    = '0;
        any    = 1'b0;
        for (int i = 0; i < N; i++) begin
            d = (i + N - int'(start)) % N;
            if (req[i] && d < best_d) begin
                best_d = d;
                idx    = IW'(i);
                any    = 1'b1;
            end
        end
        gnt = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/cdb_rr_arbiter.sv
// Common data bus arbiter: one registered broadcast per cycle, round-robin.
// Define CDB_FIXED_PRIORITY_EN for legacy fixed lowest-index-wins priority.
module cdb_rr_arbiter
    import cdb_pkg::*;
#(
    parameter int N_UNITS = N_UNITS_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TAG_W   = TAG_W_DEF
) (
    input  logic           Clock,
    input  logic           Reset,
    cdb_rr_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(N_UNITS);

    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   win_idx;
    logic [N_UNITS-1:0] req;
    logic [N_UNITS-1:0] pick_gnt;
    logic               win_any;
    logic               fire;
    logic [DATA_W-1:0]  win_data;

    logic               valid_q;
    logic [TAG_W-1:0]   tag_q;
    logic [DATA_W-1:0]  data_q;

    assign req = bus.Write_Enable_CDB ? bus.Done : '0;

    rr_priority_picker #(
        .N  (N_UNITS),
        .IW (IDX_W)
    ) u_pick (
        .req   (req),
        .start (ptr),
        .gnt   (pick_gnt),
        .idx   (win_idx),
        .any   (win_any)
    );

    // Reset masks the grant so no result is consumed during reset.
    assign fire      = win_any & ~Reset;
    assign bus.Grant = fire ? pick_gnt : '0;

    always_comb begin
        win_data = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            if (pick_gnt[i]) begin
                win_data = win_data | bus.Q_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            valid_q <= 1'b0;
            tag_q   <= TAG_W'(FREE_REGISTER);
            data_q  <= '0;
        end else if (fire) begin
            valid_q <= 1'b1;
            tag_q   <= TAG_W'(unit_tag(int'(win_idx)));
            data_q  <= win_data;
        end else begin
            valid_q <= 1'b0;
        end
    end

`ifdef CDB_FIXED_PRIORITY_EN
    assign ptr = '0;
`else
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ptr <= '0;
        end else if (fire) begin
            ptr <= (win_idx == IDX_W'(N_UNITS - 1)) ? '0 : win_idx + 1'b1;
        end
    end
`endif

    assign bus.CDB_Valid   = valid_q;
    assign bus.Qi_CDB      = tag_q;
    assign bus.Qi_CDB_data = data_q;

endmodule

// File: doc/cdb_rr_arbiter.md
CDB_RR_ARBITER -- requirements
Module: cdb_rr_arbiter

Interface
REQ-001 Parameter N_UNITS, default 4, number of functional units competing for the CDB (legal range 2..7).
REQ-002 Parameter DATA_W, default 16, width of the result data.
REQ-003 Parameter TAG_W, default 3, width of the reservation-station tag; N_UNITS SHALL be at most 2^TAG_W-1.
REQ-004 Clock  input  1  single clock; all state updates on its rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 Write_Enable_CDB  input  1  global broadcast enable; 0 stalls arbitration.
REQ-007 Done  input  N_UNITS  per-unit request; bit i high means unit i holds a finished result.
REQ-008 Q_data  input  N_UNITS*DATA_W  packed results; unit i occupies bits [i*DATA_W +: DATA_W].
REQ-009 Grant  output  N_UNITS  one-hot combinational grant for the current cycle.
REQ-010 CDB_Valid  output  1  registered; high for exactly one cycle per broadcast.
REQ-011 Qi_CDB  output  TAG_W  registered tag of the broadcasting station.
REQ-012 Qi_CDB_data  output  DATA_W  registered broadcast data.

Function
REQ-013 Tag of unit i SHALL be i+1; tag 0 (FREE_REGISTER) SHALL never be broadcast with CDB_Valid high.
REQ-014 Grant SHALL be all-zero when Write_Enable_CDB is 0 or Done is all-zero; otherwise Grant SHALL have exactly one bit set, on a requesting unit.
REQ-015 Round-robin: search SHALL start at index Ptr and wrap modulo N_UNITS; the first requesting unit wins.
REQ-016 On a rising edge with Grant[i]=1: Qi_CDB<=i+1, Qi_CDB_data<=Q_data slice i, CDB_Valid<=1, Ptr<=(i+1) mod N_UNITS.
REQ-017 On a rising edge with Grant all-zero: CDB_Valid<=0; Qi_CDB, Qi_CDB_data and Ptr SHALL hold.
REQ-018 Latency: data sampled with a grant SHALL appear on the outputs in the following cycle (1 cycle).
REQ-019 Handshake: a unit SHALL hold Done and its data stable until it sees Grant at a rising edge, then drop Done in the next cycle; the arbiter does not latch ungranted requests.
REQ-020 Back-to-back: with continuous requests, one broadcast per cycle SHALL occur, with CDB_Valid held high.
REQ-021 Fairness: a unit holding Done continuously SHALL be granted within N_UNITS cycles of enabled arbitration.
REQ-022 Ptr wrap: after granting unit N_UNITS-1, Ptr SHALL be 0.

Reset
REQ-023 Reset high SHALL immediately force CDB_Valid=0, Qi_CDB=0, Qi_CDB_data=0, Ptr=0, regardless of Clock.
REQ-024 Grant SHALL be all-zero while Reset is high; a broadcast in progress SHALL be discarded, not delayed.
REQ-025 First grant after reset release SHALL go to the lowest-index requester.

Configuration
REQ-026 Macro CDB_FIXED_PRIORITY_EN defined: Ptr SHALL be constant 0 and the lowest-index requester always wins (legacy two-unit behaviour, no fairness guarantee; REQ-021 waived).
REQ-027 Macro undefined: round-robin per REQ-015..REQ-022.

Structure
REQ-028 Package cdb_pkg SHALL hold FREE_REGISTER=0, default widths and the unit-index-to-tag function.
REQ-029 Sub-module rr_priority_picker (request vector, start pointer -> one-hot grant, winner index) SHALL implement the wrap-around search.

Verification
REQ-030 N_UNITS=4; Done=4'b0011, data1=16'h00AA, data2=16'h00BB, enable=1 from reset -> cycle 1 Qi_CDB=1/h00AA, cycle 2 Qi_CDB=2/h00BB, CDB_Valid high both cycles.
REQ-031 Done=4'b1111 held for 8 cycles -> tag sequence 1,2,3,4,1,2,3,4, no gaps.
REQ-032 Done=4'b0100, Write_Enable_CDB=0 for 3 cycles then 1 -> Grant=0 and CDB_Valid=0 for 3 cycles; Qi_CDB=3 one cycle after enable rises.
REQ-033 Reset asserted mid-cycle while Grant=4'b1000 -> outputs 0 immediately; after release with Done=4'b1000 -> Qi_CDB=4 next cycle.
REQ-034 CDB_FIXED_PRIORITY_EN defined, Done=4'b1001 held -> Qi_CDB=1 every cycle; unit 4 never granted.
REQ-035 Random Done/data for 10000 cycles -> scoreboard: every granted result broadcast exactly once, in grant order, tag never 0, per-unit wait at most 4 cycles.
